// File: rtl/inst_fetch_stage_if.sv
// Bundle between the fetch stage, the instruction SRAM and decode.
// The fetch stage uses the master modport; the slave modport is the SRAM/decode side.
interface inst_fetch_stage_if;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_ready;

    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output fs_valid, fs_pc, fs_inst,
        input  inst_sram_rdata, br_valid, br_target, ds_ready
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  fs_valid, fs_pc, fs_inst,
        output inst_sram_rdata, br_valid, br_target, ds_ready
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: sequential SRAM reads with one-cycle latency, a small
// {pc, inst} FIFO towards decode, and a flush on branch redirect.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_stage_if.master bus
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic          rsp_pending;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   in_flight;
    logic          unused_br_bits;

    assign unused_br_bits = &{1'b0, bus.br_target[1:0]};

    assign pop  = bus.fs_valid & bus.ds_ready;
    assign push = rsp_pending & ~bus.br_valid;

    // Credit check: entries held plus the one in flight, minus the one leaving now.
    assign in_flight = {1'b0, count} + {{CW{1'b0}}, rsp_pending} - {{CW{1'b0}}, pop};
    assign issue     = ~reset & ~bus.br_valid & (in_flight < DEPTH_W);

    assign bus.inst_sram_en    = issue;
    assign bus.inst_sram_we    = 1'b0;
    assign bus.inst_sram_addr  = fetch_pc;
    assign bus.inst_sram_wdata = 32'h0;

    assign bus.fs_valid = (count != '0);
    assign bus.fs_pc    = pc_mem[rd_ptr];
    assign bus.fs_inst  = inst_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pending <= 1'b0;
            rsp_pc      <= 32'h0;
        end else if (bus.br_valid) begin
            fetch_pc    <= {bus.br_target[31:2], 2'b00};
            rsp_pending <= 1'b0;
        end else begin
            rsp_pending <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                rsp_pc   <= fetch_pc;
            end
        end
    end

    // A redirect discards every held entry; a pop in that cycle was already taken by decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.br_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            inst_mem[wr_ptr] <= bus.inst_sram_rdata;
        end
    end
endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage: per-cycle vectors check the SRAM side,
// a scoreboard checks every instruction handed to decode.
module tb_inst_fetch_stage;
    localparam logic [31:0] P   = 32'h1c00_0000;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    typedef struct packed {
        logic        ready;
        logic        brv;
        logic [31:0] tgt;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic        chk_head;
        logic [31:0] head;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];
    exp_t sb_q[$];

    inst_fetch_stage_if bus();

    inst_fetch_stage #(.RESET_PC(P), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM model: data for the address presented in the previous cycle.
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= bus.inst_sram_addr ^ KEY;
    end

    task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", what, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic brv, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.ds_ready  = ready;
        bus.br_valid  = brv;
        bus.br_target = tgt;
    endtask

    task automatic addVec(input logic ready, input logic brv, input logic [31:0] tgt, input logic en,
                          input logic [31:0] addr, input logic valid, input logic chk_head,
                          input logic [31:0] head);
        vec_t v;
        v = '{ready: ready, brv: brv, tgt: tgt, en: en, addr: addr, valid: valid,
              chk_head: chk_head, head: head};
        vecs.push_back(v);
    endtask

    task automatic pushExp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = pc ^ KEY;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every accepted handshake must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && bus.fs_valid && bus.ds_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pop actual_pc=%h required=no_delivery", bus.fs_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("pop_pc", bus.fs_pc, e.pc);
                checkOutput("pop_inst", bus.fs_inst, e.inst);
            end
        end
    end

    // Reset lands between edges so its effect must be immediate.
    task automatic asyncReset(input string name);
        #2;
        reset = 1'b1;
        #1;
        checkOutput($sformatf("%s_rst_en", name), 32'(bus.inst_sram_en), 32'h0);
        checkOutput($sformatf("%s_rst_valid", name), 32'(bus.fs_valid), 32'h0);
        checkOutput($sformatf("%s_rst_addr", name), bus.inst_sram_addr, P);
        checkOutput($sformatf("%s_drained", name), 32'(sb_q.size()), 32'h0);
        sb_q.delete();
        @(posedge clk);
    endtask

    task automatic runPhase(input string name);
        for (int c = 0; c < vecs.size(); c++) begin
            vec_t v;
            v = vecs[c];
            applyStimulus(1'b0, v.ready, v.brv, v.tgt);
            @(negedge clk);
            checkOutput($sformatf("%s_en c%0d", name, c), 32'(bus.inst_sram_en), 32'(v.en));
            if (v.en)
                checkOutput($sformatf("%s_addr c%0d", name, c), bus.inst_sram_addr, v.addr);
            checkOutput($sformatf("%s_valid c%0d", name, c), 32'(bus.fs_valid), 32'(v.valid));
            if (v.chk_head)
                checkOutput($sformatf("%s_head c%0d", name, c), bus.fs_pc, v.head);
        end
        vecs.delete();
        asyncReset(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.ds_ready    = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_target   = 32'h0;
        bus.inst_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(bus.fs_valid), 32'h0);
        checkOutput("reset_en", 32'(bus.inst_sram_en), 32'h0);
        checkOutput("reset_addr", bus.inst_sram_addr, P);
        checkOutput("reset_we", 32'(bus.inst_sram_we), 32'h0);
        checkOutput("reset_wdata", bus.inst_sram_wdata, 32'h0);

        // Streaming with decode always ready: one instruction per cycle from cycle 2.
        for (int c = 0; c < 8; c++)
            addVec(1'b1, 1'b0, 32'h0, 1'b1, P + 32'(4 * c), c >= 2, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++)
            pushExp(P + 32'(4 * k));
        runPhase("stream");

        // Back-pressure: two requests, then stall until decode is ready in cycle 6.
        for (int c = 0; c < 9; c++)
            addVec(c >= 6, 1'b0, 32'h0, (c < 2) || (c >= 6),
                   (c < 2) ? P + 32'(4 * c) : (c <= 6) ? P + 32'h8 : P + 32'(4 * (c - 4)),
                   c >= 2, (c >= 2) && (c <= 5), P);
        pushExp(P);
        pushExp(P + 32'h4);
        pushExp(P + 32'h8);
        runPhase("stall");

        // Redirect with a full FIFO; unaligned target is word aligned.
        addVec(1'b0, 1'b0, 32'h0,         1'b1, P,           1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,         1'b1, P + 32'h4,   1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,         1'b0, P + 32'h8,   1'b1, 1'b1, P);
        addVec(1'b0, 1'b0, 32'h0,         1'b0, P + 32'h8,   1'b1, 1'b1, P);
        addVec(1'b0, 1'b1, P + 32'h103,   1'b0, P + 32'h8,   1'b1, 1'b1, P);
        addVec(1'b0, 1'b0, 32'h0,         1'b1, P + 32'h100, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,         1'b1, P + 32'h104, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,         1'b1, P + 32'h108, 1'b1, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,         1'b1, P + 32'h10C, 1'b1, 1'b0, 32'h0);
        pushExp(P + 32'h100);
        pushExp(P + 32'h104);
        runPhase("redirect_full");

        // Redirect during pop plus returning response, then back-to-back redirects.
        addVec(1'b1, 1'b0, 32'h0,          1'b1, P,            1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, P + 32'h4,    1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, P + 32'h8,    1'b1, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, P + 32'hC,    1'b1, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 32'h3000_0000,  1'b0, P + 32'h10,   1'b1, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 32'h2000_0041,  1'b0, 32'h3000_0000, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, 32'h2000_0040, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, 32'h2000_0044, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, 32'h2000_0048, 1'b1, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,          1'b1, 32'h2000_004C, 1'b1, 1'b0, 32'h0);
        pushExp(P);
        pushExp(P + 32'h4);
        pushExp(P + 32'h8);
        pushExp(32'h2000_0040);
        pushExp(32'h2000_0044);
        runPhase("redirect_pop");

        // Fetch address wraps from the top of the address space to zero.
        addVec(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, P,            1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0);
        pushExp(32'hFFFF_FFFC);
        pushExp(32'h0000_0000);
        runPhase("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
